// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: opcodes, FSM encoding and the prefetch buffer entry layout.
package mips_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [5:0] OP_J   = 6'h2;
  localparam logic [5:0] OP_JAL = 6'h3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [INST_W-1:0] word);
    return (word[31:26] == OP_J) || (word[31:26] == OP_JAL);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: register-based FIFO with a flush that empties it in one cycle.
module ifetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rptr_q];

  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a prefetch FIFO.
// Define IFETCH_JPREDECODE_EN to follow J/JAL targets at fetch time.
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] instruction,
  output logic [31:0]       inst_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_seq, pc_push, pc_redirect;
  logic         push, pop, fifo_full, fifo_empty;
  fetch_entry_t push_entry, head_entry;

  assign pc_seq      = pc_q + 32'd4;
  assign pc_redirect = redirect_pc & 32'hFFFF_FFFC;

  // Redirect wins over a response landing in the same cycle.
  assign push = (state_q == StWait) && imem_rvalid && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  assign push_entry = '{inst: imem_rdata, pc: pc_q};

  ifetch_fifo #(
    .Depth(FIFO_DEPTH),
    .Width($bits(fetch_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push (push),
    .wdata(push_entry),
    .pop  (pop),
    .rdata(head_entry),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign inst_valid  = !fifo_empty;
  assign instruction = head_entry.inst;
  assign inst_pc     = head_entry.pc;
  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;

  always_comb begin
    pc_push = pc_seq;
`ifdef IFETCH_JPREDECODE_EN
    if (is_jump(imem_rdata)) begin
      pc_push = {pc_seq[31:28], imem_rdata[25:0], 2'b00};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;

    unique case (state_q)
      // Nothing is in flight in idle, so any free slot allows a new request.
      StIdle: if (!fifo_full) state_d = StReq;
      StReq:  if (imem_gnt) state_d = StWait;
      StWait: if (imem_rvalid) state_d = StIdle;
      StDrop: if (imem_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (push) pc_d = pc_push;

    if (redirect_valid) begin
      pc_d = pc_redirect;
      // A response is still owed if a grant was given and its data has not arrived yet.
      if (((state_q == StWait) || (state_q == StDrop)) && !imem_rvalid) begin
        state_d = StDrop;
      end else if ((state_q == StReq) && imem_gnt) begin
        state_d = StDrop;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a memory responder, a transfer monitor and directed stimulus.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  int unsigned rsp_delay = 1;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] sb_q[$];

  logic        rsp_pend = 1'b0;
  int unsigned rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;
  logic        rsp_g;
  logic [31:0] rsp_ga;

  logic        hold_prev = 1'b0;
  logic [31:0] hold_inst = '0;
  logic [31:0] hold_pc = '0;
  logic [63:0] mon_e;

`ifdef IFETCH_JPREDECODE_EN
  localparam logic [31:0] JNext = 32'h0000_0100;
`else
  localparam logic [31:0] JNext = 32'h0000_0014;
`endif

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .instruction   (instruction),
    .inst_pc       (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h10) return 32'h0800_0040;
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    int k;
    k = 0;
    while (!imem_req && k < 40) begin
      step(1);
      k++;
    end
    chk({name, "_req"}, 32'(imem_req), 32'd1);
    chk({name, "_addr"}, imem_addr, exp_addr);
  endtask

  // Expects a full two-entry buffer holding a0 then a1; releases exactly two transfers.
  task automatic drain2(input logic [31:0] a0, input logic [31:0] a1);
    sb_q.push_back({mem_word(a0), a0});
    sb_q.push_back({mem_word(a1), a1});
    inst_ready = 1'b1;
    step(2);
    inst_ready = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Memory: rvalid arrives rsp_delay cycles after the grant cycle; survives DUT reset.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      rsp_g  = imem_req && imem_gnt;
      rsp_ga = imem_addr;
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (rsp_g) begin
        rsp_pend = 1'b1;
        rsp_addr = rsp_ga;
        rsp_cnt  = rsp_delay;
      end
      if (rsp_pend) begin
        if (rsp_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(rsp_addr);
          rsp_pend    = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
    end
  end

  // Monitor: every transfer must match the scoreboard head; a stalled head must not move.
  initial begin
    forever begin
      @(negedge clk);
      if (hold_prev && rst_n && inst_valid) begin
        chk("hold_inst", instruction, hold_inst);
        chk("hold_pc", inst_pc, hold_pc);
      end
      if (rst_n && inst_valid && inst_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_xfer: got pc %h, want no transfer", inst_pc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("xfer_inst", instruction, mon_e[63:32]);
          chk("xfer_pc", inst_pc, mon_e[31:0]);
        end
      end
      hold_prev = rst_n && inst_valid && !inst_ready;
      hold_inst = instruction;
      hold_pc   = inst_pc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    imem_gnt       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", instruction, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);

    // First fetch after reset, then back-pressure until the buffer is full.
    imem_gnt = 1'b1;
    rst_n    = 1'b1;
    step(1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(1);
    chk("valid_before_push", 32'(inst_valid), 32'd0);
    step(1);
    chk("valid_after_rvalid", 32'(inst_valid), 32'd1);
    chk("first_inst", instruction, 32'h2001_0005);
    chk("first_pc", inst_pc, 32'h0);
    step(1);
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", imem_addr, 32'h4);
    step(8);
    chk("full_req_stops", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_head_pc", inst_pc, 32'h0);
    chk("full_fetch_pc", imem_addr, 32'h8);
    drain2(32'h0, 32'h4);

    // Redirect while a response is in flight: it must be dropped.
    rsp_delay = 3;
    redirect(32'h200);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    wait_req("redir_a", 32'h200);
    step(1);
    redirect(32'h103);
    chk("drop_req_low", 32'(imem_req), 32'd0);
    wait_req("redir_b", 32'h100);
    chk("drop_empty", 32'(inst_valid), 32'd0);

    // Redirect and transfer in the same cycle.
    rsp_delay = 1;
    step(16);
    chk("refill_valid", 32'(inst_valid), 32'd1);
    chk("refill_pc", inst_pc, 32'h100);
    sb_q.push_back({mem_word(32'h100), 32'h100});
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step(1);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    chk("xfer_flush_valid", 32'(inst_valid), 32'd0);
    chk("xfer_once", 32'(sb_q.size()), 32'd0);
    step(16);
    chk("new_path_head", inst_pc, 32'h300);
    drain2(32'h300, 32'h304);

    // Jump word at 0x10.
    redirect(32'h10);
    wait_req("jmp_a", 32'h10);
    step(1);
    wait_req("jmp_next", JNext);
    step(16);
    drain2(32'h10, JNext);

    // Address wrap.
    redirect(32'hFFFF_FFFE);
    wait_req("wrap_a", 32'hFFFF_FFFC);
    step(1);
    wait_req("wrap_b", 32'h0);
    step(16);
    drain2(32'hFFFF_FFFC, 32'h0);

    // Reset during WAIT; the late response lands while the DUT is in REQ.
    rsp_delay = 4;
    redirect(32'h40);
    wait_req("rst_mid_a", 32'h40);
    step(1);
    imem_gnt = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid_req", 32'(imem_req), 32'd0);
    chk("rst_mid_addr", imem_addr, 32'h0);
    chk("rst_mid_valid", 32'(inst_valid), 32'd0);
    chk("rst_mid_inst", instruction, 32'h0);
    chk("rst_mid_pc", inst_pc, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(3);
    imem_gnt  = 1'b1;
    rsp_delay = 1;
    wait_req("rst_mid_b", 32'h0);
    chk("stale_ignored", 32'(inst_valid), 32'd0);
    step(16);
    drain2(32'h0, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: number of prefetch buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req, output, 1: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32: fetch byte address, word aligned.
REQ-007 SHALL have port imem_gnt, input, 1: memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1: read data valid, at least one cycle after gnt, in order.
REQ-009 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1: branch or jump redirect from downstream.
REQ-011 SHALL have port redirect_pc, input, 32: redirect target.
REQ-012 SHALL have port inst_valid, output, 1: the instruction output is valid.
REQ-013 SHALL have port inst_ready, input, 1: the decode stage (instruction parser) accepts the instruction.
REQ-014 SHALL have port instruction, output, 32: the 32-bit word handed to the instruction parser.
REQ-015 SHALL have port inst_pc, output, 32: the byte address of that instruction.

Function
REQ-016 SHALL run an FSM with states IDLE, REQ, WAIT and DROP: IDLE->REQ when free slots exceed the in-flight count; REQ->WAIT on imem_gnt; WAIT->IDLE on imem_rvalid; DROP->IDLE on imem_rvalid.
REQ-017 SHALL allow at most one outstanding request; imem_req and imem_addr SHALL be held stable in REQ until imem_gnt.
REQ-018 SHALL push {imem_rdata, fetch pc} into the FIFO on imem_rvalid in WAIT, then set fetch pc = fetch pc + 4 (mod 2^32, wrapping from 32'hFFFF_FFFC to 0).
REQ-019 SHALL drive instruction, inst_pc and inst_valid from the FIFO head; a transfer occurs when inst_valid and inst_ready are both high; instruction and inst_pc SHALL hold while inst_valid is high and inst_ready is low.
REQ-020 SHALL assert inst_valid, from a registered output, the cycle after the imem_rvalid that filled an empty FIFO.
REQ-021 SHALL, on redirect_valid: flush the FIFO, drop imem_req, and set fetch pc = {redirect_pc[31:2], 2'b00}; from WAIT, or from REQ with gnt in the same cycle, it SHALL enter DROP; otherwise it SHALL enter IDLE.
REQ-022 SHALL complete a redirect and a transfer in the same cycle: the consumer owns the transferred word, and flush still applies; redirect SHALL take priority over an imem_rvalid push in the same cycle.
REQ-023 SHALL, when the FIFO is full, stop issuing requests without dropping any entry; a push and a pop in the same cycle SHALL both occur.
REQ-024 SHALL ignore imem_rvalid in IDLE and REQ.

Reset
REQ-025 SHALL, while rst_n is low, force: imem_req=0, imem_addr=RESET_PC, inst_valid=0, instruction=0, inst_pc=0, FIFO empty, state IDLE, fetch pc=RESET_PC.
REQ-026 SHALL assert imem_req in the first cycle after rst_n deasserts; a stale response arriving after a mid-transaction reset SHALL be discarded per REQ-024.

Configuration
REQ-027 SHALL, when IFETCH_JPREDECODE_EN is defined, recognise opcode imem_rdata[31:26] equal to 6'h2 or 6'h3 on a WAIT push, still enqueue the word, and set the next fetch pc = {(pc+4)[31:28], imem_rdata[25:0], 2'b00}.
REQ-028 SHALL, when IFETCH_JPREDECODE_EN is undefined, fetch strictly sequentially; jumps are handled only through redirect.

Structure
REQ-029 SHALL take OP_J (6'h2), OP_JAL (6'h3), the FSM state encoding and INST_W (32) from the shared package mips_pkg.
REQ-030 SHALL implement the prefetch buffer as sub-module ifetch_fifo, with push/pop/full/empty and a flush input.

Verification
REQ-031 Reset then gnt=1 and 1-cycle rvalid with data 0x2001_0005 -> imem_addr=0x0 first, inst_valid one cycle after rvalid, instruction=0x2001_0005, inst_pc=0x0, next address 0x4.
REQ-032 Hold inst_ready=0 for 10 cycles -> FIFO fills to 2, imem_req stops, no word is lost; release -> words delivered with inst_pc 0x0 then 0x4, in order.
REQ-033 Redirect to 0x0000_0103 while in WAIT -> in-flight response dropped, FIFO empty, next imem_addr=0x0000_0100.
REQ-034 Redirect and transfer in the same cycle -> the word is consumed once, the FIFO is flushed, and no old-path word appears afterwards.
REQ-035 With IFETCH_JPREDECODE_EN defined, word 0x0800_0040 at pc 0x10 -> the word is enqueued and the next imem_addr=0x0000_0100; with the macro undefined, the next imem_addr=0x14.
REQ-036 Fetch pc 0xFFFF_FFFC -> the next address wraps to 0x0; rst_n pulsed low during WAIT -> outputs go to reset values immediately and a late rvalid is ignored.
